// File: rtl/vec_sub_stream.sv
// vec_sub_stream: streaming element-wise vector subtractor, out[i] = x[i] - y[i].
// Pops one operand pair per cycle from upstream FWFT FIFOs. Each difference
// vector is pushed into an internal FWFT output FIFO that downstream reads.
// Optional build macro VEC_SUB_SATURATE_EN: when it is defined, each lane
// saturates to the signed range instead of wrapping. Latency, handshake and
// FIFO behaviour are the same in both builds.
module vec_sub_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_SIZE = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] x,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] y,
  input  logic                                  in_empty,
  output logic                                  in_rd_en,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out,
  output logic                                  out_empty,
  input  logic                                  out_rd_en
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

  // Subtracts one lane. Overflow can only happen when the operand signs differ
  // and the result sign differs from the minuend sign.
  function automatic logic [DATA_WIDTH-1:0] lane_sub(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] diff;
    diff = a - b;
`ifdef VEC_SUB_SATURATE_EN
    if ((a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
      if (a[DATA_WIDTH-1]) begin
        diff = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        diff = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
`endif
    return diff;
  endfunction

  vec_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  vec_t            diff_s;
  logic            out_full_s;
  logic            push_s;
  logic            pop_s;

  // Handshake: accept a pair only when one is present and the FIFO has room.
  always_comb begin
    out_full_s = (count_q == CW'(FIFO_DEPTH));
    in_rd_en   = !reset && !in_empty && !out_full_s;
    push_s     = in_rd_en;
    out_empty  = (count_q == {CW{1'b0}});
    pop_s      = out_rd_en && !out_empty;
  end

  // Lane-wise difference of the current operand pair.
  always_comb begin
    diff_s = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      diff_s[i] = lane_sub(x[i], y[i]);
    end
  end

  // Next-state pointers and occupancy. A push and a pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state, cleared asynchronously so buffered results are discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage. It is unreset; validity comes from count_q.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= diff_s;
    end
  end

  // FWFT head. It reads zero while empty, so stale storage is never exposed.
  always_comb begin
    if (out_empty) begin
      out = '0;
    end else begin
      out = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_vec_sub_stream.sv
// Self-checking bench for vec_sub_stream. It uses directed table vectors and
// then checks reset, backpressure, empty-read and streaming sequences.
module tb_vec_sub_stream;

  localparam int DW = 32;
  localparam int AS = 3;
  localparam int FD = 16;
  localparam int NSTREAM = 1000;

  typedef logic [AS-1:0][DW-1:0] vec_t;

  typedef struct {
    vec_t vx;
    vec_t vy;
    vec_t ew;
    vec_t es;
  } vec_rec_t;

  logic clock = 1'b0;
  logic reset;
  vec_t x, y, out;
  logic in_empty, in_rd_en, out_empty, out_rd_en;

  int checks = 0;
  int errors = 0;

  vec_sub_stream #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out(out), .out_empty(out_empty), .out_rd_en(out_rd_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    return {a2, a1, a0};
  endfunction

  // Reference subtraction done in wide signed arithmetic.
  function automatic vec_t model(input vec_t a, input vec_t b);
    vec_t r;
    longint d;
    for (int i = 0; i < AS; i++) begin
      d = longint'($signed(a[i])) - longint'($signed(b[i]));
`ifdef VEC_SUB_SATURATE_EN
      if (d > 64'sd2147483647) d = 64'sd2147483647;
      if (d < -64'sd2147483648) d = -64'sd2147483648;
`endif
      r[i] = 32'(d);
    end
    return r;
  endfunction

  vec_rec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int take;
    int sent;
    int recv;
    int cyc;
    vec_t nx, ny, ev;
    vec_t q[$];

    tbl[0] = '{v3(32'd5, 32'd10, -32'sd3), v3(32'd2, 32'd20, -32'sd3),
               v3(32'd3, -32'sd10, 32'd0), v3(32'd3, -32'sd10, 32'd0)};
    tbl[1] = '{v3(32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF), v3(32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF),
               v3(32'h7FFFFFFF, 32'h80000000, 32'h80000000), v3(32'h80000000, 32'h7FFFFFFF, 32'h80000000)};
    tbl[2] = '{v3(32'd0, 32'd0, 32'h80000000), v3(32'd0, 32'h80000000, 32'h80000000),
               v3(32'd0, 32'h80000000, 32'd0), v3(32'd0, 32'h7FFFFFFF, 32'd0)};
    tbl[3] = '{v3(32'd100, -32'sd100, 32'h12345678), v3(-32'sd50, -32'sd100, 32'h02345678),
               v3(32'd150, 32'd0, 32'h10000000), v3(32'd150, 32'd0, 32'h10000000)};

    // Reset state
    reset = 1'b1; in_empty = 1'b0; out_rd_en = 1'b0; x = '0; y = '0;
    #12;
    check("reset_out_empty", out_empty, 1'b1);
    check("reset_in_rd_en", in_rd_en, 1'b0);
    check("reset_out", out, '0);
    in_empty = 1'b1;
    @(negedge clock); reset = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 4; i++) begin
`ifdef VEC_SUB_SATURATE_EN
      ev = tbl[i].es;
`else
      ev = tbl[i].ew;
`endif
      @(negedge clock);
      x = tbl[i].vx; y = tbl[i].vy; in_empty = 1'b0; out_rd_en = 1'b0;
      #1;
      check("tbl_in_rd_en", in_rd_en, 1'b1);
      check("tbl_no_bypass", out_empty, 1'b1);
      @(negedge clock);
      in_empty = 1'b1;
      #1;
      check("tbl_out_empty_fell", out_empty, 1'b0);
      check("tbl_out", out, ev);
      out_rd_en = 1'b1;
      @(negedge clock);
      out_rd_en = 1'b0;
      #1;
      check("tbl_empty_after_pop", out_empty, 1'b1);
    end

    // Backpressure: offer 20 vectors with no downstream reads
    @(negedge clock);
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      x = v3(32'(3 * acc), 32'(acc), 32'd100);
      y = v3(32'd1, 32'd2, 32'(acc));
      in_empty = (acc < 20) ? 1'b0 : 1'b1;
      #1;
      take = int'(in_rd_en);
      @(negedge clock);
      acc += take;
    end
    check("bp_accepted", 96'(acc), 96'd16);
    in_empty = 1'b0;
    #1;
    check("bp_in_rd_en_full", in_rd_en, 1'b0);
    in_empty = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("bp_drain_order", out, v3(32'(3 * i - 1), 32'(i - 2), 32'(100 - i)));
      out_rd_en = 1'b1;
      @(negedge clock);
    end
    out_rd_en = 1'b0;
    #1;
    check("bp_drained_empty", out_empty, 1'b1);

    // Reads while empty must not change state
    @(negedge clock);
    out_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("empty_read_stays_empty", out_empty, 1'b1);
    end
    out_rd_en = 1'b0;
    x = v3(32'd7, 32'd8, 32'd9); y = v3(32'd1, 32'd1, 32'd1); in_empty = 1'b0;
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    check("empty_read_then_push", out, v3(32'd6, 32'd7, 32'd8));
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    #1;
    check("empty_read_count_ok", out_empty, 1'b1);

    // Mid-stream asynchronous reset
    x = v3(32'd11, 32'd22, 32'd33); y = v3(32'd1, 32'd2, 32'd3); in_empty = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_out_empty", out_empty, 1'b1);
    check("midreset_in_rd_en", in_rd_en, 1'b0);
    check("midreset_out", out, '0);
    in_empty = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    #1;
    check("postreset_no_stale", out_empty, 1'b1);
    x = v3(32'd40, 32'd50, 32'd60); y = v3(32'd1, 32'd2, 32'd3); in_empty = 1'b0;
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    check("postreset_fresh", out, v3(32'd39, 32'd48, 32'd57));
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    #1;
    check("postreset_single", out_empty, 1'b1);

    // Streaming random vectors, popping whenever data is present
    @(negedge clock);
    sent = 0; recv = 0; cyc = 0;
    nx = {$urandom, $urandom, $urandom};
    ny = {$urandom, $urandom, $urandom};
    while (recv < NSTREAM && cyc < 3000) begin
      x = nx; y = ny;
      in_empty = (sent < NSTREAM) ? 1'b0 : 1'b1;
      out_rd_en = !out_empty;
      #1;
      if (out_rd_en) begin
        if (q.size() == 0) begin
          check("stream_unexpected_output", out, '0);
        end else begin
          check("stream_data", out, q.pop_front());
        end
        recv++;
      end
      if (in_rd_en) begin
        q.push_back(model(nx, ny));
        sent++;
        nx = {$urandom, $urandom, $urandom};
        ny = {$urandom, $urandom, $urandom};
      end
      @(negedge clock);
      cyc++;
    end
    out_rd_en = 1'b0;
    in_empty = 1'b1;
    check("stream_count", 96'(recv), 96'(NSTREAM));
    check("stream_throughput", 96'(cyc <= NSTREAM + 2), 96'd1);
    #1;
    check("stream_final_empty", out_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
